// File: rtl/stopwatch_counter_if.sv
// Button inputs and display/status outputs of the stopwatch core.
// fsm_state mirrors the control state register for observation only.
interface stopwatch_counter_if;
    logic       start_stop_btn;
    logic       clear_btn;
    logic       lap_btn;
    logic [3:0] seconds_ones_counter;
    logic [3:0] seconds_tens_counter;
    logic [3:0] minutes_ones_counter;
    logic [3:0] minutes_tens_counter;
    logic       running;
    logic       lap_active;
    logic       rollover;
    logic [1:0] fsm_state;

    modport master (
        output start_stop_btn, clear_btn, lap_btn,
        input  seconds_ones_counter, seconds_tens_counter,
        input  minutes_ones_counter, minutes_tens_counter,
        input  running, lap_active, rollover, fsm_state
    );

    modport slave (
        input  start_stop_btn, clear_btn, lap_btn,
        output seconds_ones_counter, seconds_tens_counter,
        output minutes_ones_counter, minutes_tens_counter,
        output running, lap_active, rollover, fsm_state
    );
endinterface

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: button conditioning, IDLE/RUN/PAUSE control,
// 1 Hz prescaler, MM:SS BCD count and lap freeze of the displayed digits.
module stopwatch_counter #(
    parameter int unsigned TICK_DIV        = 100_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    stopwatch_counter_if.slave  sw
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_e;

    // Button index 0 = start_stop, 1 = clear, 2 = lap.
    logic [2:0]    btn_raw;
    logic [2:0]    meta_q, meta_d;
    logic [2:0]    sync_q, sync_d;
    logic [2:0]    db_q, db_d;
    logic [2:0]    press_q, press_d;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    s1_q, s1_d, s10_q, s10_d, m1_q, m1_d, m10_q, m10_d;
    logic [15:0]   snap_q, snap_d;
    logic          lap_active_q, lap_active_d;
    logic          rollover_q, rollover_d;

    logic          ss_press, clr_press, lap_press;
    logic          clear_go;
    logic          tick;
    logic [15:0]   live;
    logic [15:0]   disp;

    assign btn_raw   = {sw.lap_btn, sw.clear_btn, sw.start_stop_btn};
    assign ss_press  = press_q[0];
    assign clr_press = press_q[1];
    assign lap_press = press_q[2];
    assign clear_go  = (state_q == ST_PAUSE) && clr_press;
    assign tick      = (state_q == ST_RUN) && (presc_q == PRESC_MAX);
    assign live      = {m10_q, m1_q, s10_q, s1_q};

    // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive
    // cycle in which the synced level differs from the debounced one.
    always_comb begin
        meta_d  = btn_raw;
        sync_d  = meta_q;
        db_d    = db_q;
        press_d = '0;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (sync_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i]    = sync_q[i];
                    press_d[i] = sync_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ss_press) state_d = ST_RUN;
            ST_RUN:   if (ss_press) state_d = ST_PAUSE;
            ST_PAUSE: begin
                if (clr_press)     state_d = ST_IDLE;
                else if (ss_press) state_d = ST_RUN;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        presc_d = presc_q;
        if (state_q == ST_IDLE || clear_go) begin
            presc_d = '0;
        end else if (state_q == ST_RUN) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end
    end

    always_comb begin
        s1_d       = s1_q;
        s10_d      = s10_q;
        m1_d       = m1_q;
        m10_d      = m10_q;
        rollover_d = 1'b0;
        if (clear_go) begin
            s1_d  = '0;
            s10_d = '0;
            m1_d  = '0;
            m10_d = '0;
        end else if (tick) begin
            if (s1_q == 4'd9) begin
                s1_d = '0;
                if (s10_q == 4'd5) begin
                    s10_d = '0;
                    if (m1_q == 4'd9) begin
                        m1_d = '0;
                        if (m10_q == 4'd5) begin
                            m10_d      = '0;
                            rollover_d = 1'b1;
                        end else begin
                            m10_d = m10_q + 4'd1;
                        end
                    end else begin
                        m1_d = m1_q + 4'd1;
                    end
                end else begin
                    s10_d = s10_q + 4'd1;
                end
            end else begin
                s1_d = s1_q + 4'd1;
            end
        end
    end

    always_comb begin
        lap_active_d = lap_active_q;
        snap_d       = snap_q;
        if (clear_go) begin
            lap_active_d = 1'b0;
        end else if (lap_press) begin
            if (lap_active_q) begin
                lap_active_d = 1'b0;
            end else if (state_q == ST_RUN) begin
                lap_active_d = 1'b1;
                snap_d       = live;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q       <= '0;
            sync_q       <= '0;
            db_q         <= '0;
            press_q      <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            s1_q         <= '0;
            s10_q        <= '0;
            m1_q         <= '0;
            m10_q        <= '0;
            snap_q       <= '0;
            lap_active_q <= 1'b0;
            rollover_q   <= 1'b0;
        end else begin
            meta_q       <= meta_d;
            sync_q       <= sync_d;
            db_q         <= db_d;
            press_q      <= press_d;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q      <= state_d;
            presc_q      <= presc_d;
            s1_q         <= s1_d;
            s10_q        <= s10_d;
            m1_q         <= m1_d;
            m10_q        <= m10_d;
            snap_q       <= snap_d;
            lap_active_q <= lap_active_d;
            rollover_q   <= rollover_d;
        end
    end

    assign disp                    = lap_active_q ? snap_q : live;
    assign sw.seconds_ones_counter = disp[3:0];
    assign sw.seconds_tens_counter = disp[7:4];
    assign sw.minutes_ones_counter = disp[11:8];
    assign sw.minutes_tens_counter = disp[15:12];
    assign sw.running              = (state_q == ST_RUN);
    assign sw.lap_active           = lap_active_q;
    assign sw.rollover             = rollover_q;
    assign sw.fsm_state            = state_q;

endmodule

// File: tb/tb_stopwatch_counter.sv
// Bench for stopwatch_counter: directed scenarios plus randomized button
// activity, compared every cycle against a seconds-based reference model.
module tb_stopwatch_counter;

    localparam int TICK = 4;
    localparam int DB   = 3;

    logic clk;
    logic rst;

    stopwatch_counter_if sw_if ();

    stopwatch_counter #(
        .TICK_DIV        (TICK),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .sw  (sw_if)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            if (tests_failed <= 20)
                $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: whole seconds elapsed, mode as small integers.
    int          m_mode;     // 0 idle, 1 run, 2 pause
    int          m_presc;
    int          m_secs;
    int          m_snap;
    bit          m_lap;
    bit          m_roll;
    logic [2:0]  m_db;
    logic [2:0]  m_press;
    logic [2:0]  raw_hist[$];
    logic [15:0] exp_q[$];
    int          dut_roll_cnt;
    int          m_roll_cnt;

    function automatic logic [15:0] to_bcd(input int secs);
        int mm, ss;
        mm = secs / 60;
        ss = secs % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_presc = 0;
        m_secs  = 0;
        m_snap  = 0;
        m_lap   = 0;
        m_roll  = 0;
        m_db    = '0;
        m_press = '0;
        raw_hist.delete();
        repeat (DB + 2) raw_hist.push_back(3'b000);
    endtask

    task automatic model_edge(input logic [2:0] raw);
        logic [2:0] new_press;
        bit ss, cl, lp, tick, clear_go, all_diff;
        int n;
        raw_hist.push_back(raw);
        if (raw_hist.size() > DB + 3) void'(raw_hist.pop_front());
        n = raw_hist.size();
        // A button level is accepted once DB consecutive synced samples
        // (raw delayed two cycles) all disagree with the accepted level.
        new_press = '0;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1;
            for (int j = n - 2 - DB; j <= n - 3; j++)
                if (raw_hist[j][b] == m_db[b]) all_diff = 0;
            if (all_diff) begin
                m_db[b]      = ~m_db[b];
                new_press[b] = m_db[b];
            end
        end
        ss = m_press[0];
        cl = m_press[1];
        lp = m_press[2];
        tick     = (m_mode == 1) && (m_presc == TICK - 1);
        clear_go = (m_mode == 2) && cl;
        m_roll   = tick && (m_secs == 3599);
        if (m_roll) m_roll_cnt++;
        if (clear_go) begin
            m_lap = 0;
        end else if (lp) begin
            if (m_lap) m_lap = 0;
            else if (m_mode == 1) begin
                m_lap  = 1;
                m_snap = m_secs;
            end
        end
        if (clear_go)    m_secs = 0;
        else if (tick)   m_secs = (m_secs + 1) % 3600;
        if (m_mode == 0 || clear_go) m_presc = 0;
        else if (m_mode == 1)        m_presc = tick ? 0 : m_presc + 1;
        if (clear_go)    m_mode = 0;
        else if (ss)     m_mode = (m_mode == 1) ? 2 : 1;
        m_press = new_press;
    endtask

    task automatic check_outputs();
        logic [15:0] got, exp;
        exp_q.push_back(to_bcd(m_lap ? m_snap : m_secs));
        got = {sw_if.minutes_tens_counter, sw_if.minutes_ones_counter,
               sw_if.seconds_tens_counter, sw_if.seconds_ones_counter};
        exp = exp_q.pop_front();
        check_eq("digits", got, exp);
        check_eq("running", 16'(sw_if.running), 16'(m_mode == 1));
        check_eq("lap_active", 16'(sw_if.lap_active), 16'(m_lap));
        check_eq("rollover", 16'(sw_if.rollover), 16'(m_roll));
        if (sw_if.rollover === 1'b1) dut_roll_cnt++;
    endtask

    // driver tasks
    task automatic step();
        logic [2:0] raw;
        logic       r;
        raw = {sw_if.lap_btn, sw_if.clear_btn, sw_if.start_stop_btn};
        r   = rst;
        @(posedge clk);
        if (r) model_reset();
        else   model_edge(raw);
        #1;
        check_outputs();
    endtask

    task automatic drive(input logic ss, input logic cl, input logic lp, input int cycles);
        sw_if.start_stop_btn = ss;
        sw_if.clear_btn      = cl;
        sw_if.lap_btn        = lp;
        repeat (cycles) step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 2);
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        sw_if.start_stop_btn = 1'b0;
        sw_if.clear_btn      = 1'b0;
        sw_if.lap_btn        = 1'b0;
        dut_roll_cnt = 0;
        m_roll_cnt   = 0;
        model_reset();
        do_reset();
        check_eq("reset_digits", sw_if.seconds_ones_counter, 16'd0);

        // Press latency and first ticks.
        drive(1'b1, 1'b0, 1'b0, 5);
        check_eq("press_before_run", 16'(sw_if.running), 16'd0);
        step();
        check_eq("press_to_run", 16'(sw_if.running), 16'd1);
        drive(1'b0, 1'b0, 1'b0, 4);
        check_eq("first_tick", 16'(sw_if.seconds_ones_counter), 16'd1);
        drive(1'b0, 1'b0, 1'b0, 8);
        check_eq("third_tick", 16'(sw_if.seconds_ones_counter), 16'd3);

        // Short glitches must not start the watch; one stable press does.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1);
        drive(1'b0, 1'b0, 1'b0, 4);
        drive(1'b1, 1'b0, 1'b0, 2);
        drive(1'b0, 1'b0, 1'b0, 6);
        check_eq("glitch_ignored", 16'(sw_if.running), 16'd0);
        drive(1'b1, 1'b0, 1'b0, 10);
        drive(1'b0, 1'b0, 1'b0, 10);
        check_eq("single_press_run", 16'(sw_if.running), 16'd1);

        // Randomized button activity: run/pause/clear/lap mixes.
        for (int seg = 0; seg < 1500; seg++) begin
            drive(($urandom_range(0, 99) < 35), ($urandom_range(0, 99) < 30),
                  ($urandom_range(0, 99) < 30), $urandom_range(1, 8));
            drive(1'b0, 1'b0, 1'b0, $urandom_range(0, 12));
        end

        // Long run through 09:59 -> 10:00 and 59:59 -> 00:00.
        do_reset();
        dut_roll_cnt = 0;
        m_roll_cnt   = 0;
        drive(1'b1, 1'b0, 1'b0, 5);
        drive(1'b0, 1'b0, 1'b0, 3600 * TICK + 40);
        check_eq("rollover_count", 16'(dut_roll_cnt), 16'(m_roll_cnt));
        check_eq("rollover_once", 16'(dut_roll_cnt), 16'd1);
        check_eq("after_wrap_running", 16'(sw_if.running), 16'd1);

        // Reset while running with a lap held.
        drive(1'b0, 1'b0, 1'b1, 4);
        drive(1'b0, 1'b0, 1'b0, 3);
        check_eq("lap_set", 16'(sw_if.lap_active), 16'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rst_digits", {sw_if.minutes_tens_counter, sw_if.minutes_ones_counter,
                               sw_if.seconds_tens_counter, sw_if.seconds_ones_counter}, 16'd0);
        check_eq("rst_lap", 16'(sw_if.lap_active), 16'd0);
        check_eq("rst_running", 16'(sw_if.running), 16'd0);

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/stopwatch_counter.md
Name: stopwatch_counter

Overview:
Time-base and control core of the stopwatch. It conditions the raw start/stop, clear and lap buttons, and runs a RUN/PAUSE/IDLE state machine. It divides clk down to a 1 Hz tick and keeps an MM:SS BCD count. The four BCD digits feed the seven-segment display multiplexer directly downstream.

Parameters:
TICK_DIV, 100_000_000, clk cycles per 1 s tick (100 MHz board clock)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable synced cycles required to accept a button level change (10 ms)

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
start_stop_btn  input  1  raw async pushbutton, high = pressed
clear_btn  input  1  raw async pushbutton
lap_btn  input  1  raw async pushbutton
seconds_ones_counter  output  4  BCD 0-9
seconds_tens_counter  output  4  BCD 0-5
minutes_ones_counter  output  4  BCD 0-9
minutes_tens_counter  output  4  BCD 0-5
running  output  1  high in RUN state
lap_active  output  1  high while displayed digits are frozen
rollover  output  1  one-cycle pulse on 59:59 -> 00:00

Behaviour:
- Reset, synchronous: sync FFs, debounced levels, debounce counters and prescaler all 0; FSM = IDLE; all digits 0; running = 0, lap_active = 0, rollover = 0. Reset mid-count discards everything, including the lap snapshot.
- Button conditioning, identical per button:
  - 2-FF synchroniser.
  - Debounce counter: clears whenever the synced level equals the debounced level. Otherwise it increments. On reaching DEBOUNCE_CYCLES it updates the debounced level and clears.
  - A 0->1 change of the debounced level gives a one-cycle press pulse. This is the only event the FSM uses.
  - A raw level held stable from cycle N gives its pulse in cycle N+2+DEBOUNCE_CYCLES.
  - Glitches shorter than DEBOUNCE_CYCLES produce no pulse. Release produces no pulse.
- FSM states: IDLE, RUN, PAUSE.
  - start_stop press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - clear press in PAUSE: ->IDLE. All digits are zeroed, the prescaler is zeroed and lap_active is cleared, all effective the next cycle.
  - clear press in IDLE or RUN: ignored.
  - Simultaneous start_stop and clear presses while in PAUSE: clear wins, go to IDLE. In other states start_stop is processed and clear is ignored.
  - running = 1 exactly when the state is RUN (registered state).
- Prescaler, range 0..TICK_DIV-1:
  - Increments only in RUN. tick = RUN && prescaler == TICK_DIV-1, and the prescaler wraps to 0 on tick.
  - Holds its value in PAUSE, so a resume keeps the partial second.
  - Forced to 0 in IDLE.
  - Width is clog2(TICK_DIV).
- BCD cascade, advanced only on tick:
  - seconds_ones 9->0 carries into seconds_tens.
  - seconds_tens 5->0 carries into minutes_ones.
  - minutes_ones 9->0 carries into minutes_tens.
  - minutes_tens 5->0 is the full wrap.
  - On the tick at 59:59 the digits become 00:00 and rollover pulses in the same cycle the registered digits show 00:00. Counting continues in RUN after the wrap.
  - Digits never leave their legal BCD ranges.
- Lap:
  - lap press in RUN with lap_active = 0: capture the live digits into the snapshot registers (values registered at the end of the press cycle) and set lap_active.
  - lap press with lap_active = 1, in RUN or PAUSE: clear lap_active, and outputs track the live count from the next cycle.
  - lap press in PAUSE with lap_active = 0, or in IDLE: ignored.
  - While lap_active = 1, the outputs show the snapshot and the internal count keeps advancing.
  - The output mux selects snapshot vs live based on the lap_active register.
  - Same-cycle lap press and start_stop press: both are applied.
- Output latency: live digits are registers. A tick in cycle T is visible on the outputs in cycle T+1.

Test Plan:
1. Reset then basic count (TICK_DIV=4, DEBOUNCE_CYCLES=3): assert rst; start_stop held high from cycle 10 -> press pulse at cycle 15; running=1 at 16. seconds_ones reads 1 after 4 further clocks and 3 after 12.
2. Debounce: start_stop glitches of 1-2 cycles, then a stable 10-cycle press -> exactly one press pulse, FSM leaves IDLE once. Release -> no pulse.
3. Pause/resume/clear: RUN to prescaler=2 at 00:05; press start_stop -> PAUSE, digits stay 00:05 and prescaler stays 2. Press start_stop -> tick 2 cycles after RUN resumes -> 00:06. Press start_stop, then clear -> 00:00, IDLE. Clear pressed in RUN -> ignored.
4. Carries and rollover: run to 09:59 -> next tick gives 10:00. Run to 59:59 -> next tick gives 00:00 with rollover=1 for exactly one cycle; counting continues to 00:01.
5. Lap: lap press at 00:07 in RUN -> outputs frozen at 00:07, lap_active=1, internal count reaches 00:10. Lap press again -> outputs show 00:10 the next cycle. Lap pressed in PAUSE with lap_active=0 -> ignored.
6. Priority and reset mid-op: simultaneous start_stop and clear in PAUSE -> IDLE, digits 00:00. rst asserted during RUN with lap_active=1 -> all outputs 0 the next cycle.
